// File: rtl/serial_rx_pkg.sv
// Shared types and helpers for the serial receive controller.
// No logic of its own; zero latency.
// No flow control here; consumers apply their own backpressure.
package serial_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    ERR
  } rx_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  // Increment that sticks at max instead of wrapping; callers pass
  // their own all-ones value so one helper serves any counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max);
    return (val == max) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/serial_rx_ctrl_if.sv
// Byte delivery port between the receive controller and its consumer.
// Pure wiring; adds no latency.
// Consumer holds off delivery by keeping rd_ready low.
interface serial_rx_ctrl_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          rd_valid;
  logic          rd_ready;
  logic [7:0]    rd_data;
  logic [CW-1:0] fifo_count;

  modport master (output rd_valid, output rd_data, output fifo_count, input rd_ready);
  modport slave  (input rd_valid, input rd_data, input fifo_count, output rd_ready);
endinterface

// File: rtl/serial_rx_fifo.sv
// Small synchronous FIFO holding received bytes.
// Push visible at the head one cycle after the write edge.
// A push into a full FIFO is accepted only if a pop frees a slot that cycle.
module serial_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = count_q;
  assign pop_data = empty ? '0 : mem[rptr_q];

  // Storage array; contents need no reset because count gates the head.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr_q] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/serial_rx_ctrl.sv
// Receives start/8 data/optional parity/stop frames and queues good bytes.
// Byte appears on rd_valid/rd_data the cycle after the stop bit is sampled.
// Consumer backpressure via rd_ready; a good frame arriving to a full FIFO is dropped and counted.
module serial_rx_ctrl
  import serial_rx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in,
  input  logic              en,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              clr_cnt,
  serial_rx_ctrl_if.master  rd,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_err_cnt,
  output logic [CNT_W-1:0]  parity_err_cnt,
  output logic [CNT_W-1:0]  overrun_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rx_state_t  state_q, state_d;
  logic [2:0] bit_idx_q;
  logic [7:0] shreg_q;
  logic       par_en_q;
  logic       par_odd_q;
  logic       par_err_q;
  logic       par_bad;

  logic       push;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic       frame_err_inc;
  logic       par_err_inc;
  logic       overrun_inc;

  assign par_bad     = ((^shreg_q) ^ in) != par_odd_q;
  assign pop         = rd.rd_valid && rd.rd_ready;
  assign overrun_inc = push && fifo_full && !pop;
  assign rd.rd_valid = !fifo_empty;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and per-cycle strobes.
  always_comb begin
    state_d       = state_q;
    push          = 1'b0;
    frame_err_inc = 1'b0;
    par_err_inc   = 1'b0;
    busy          = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (en && (in != IDLE_LEVEL)) state_d = DATA;
      end
      DATA: begin
        if (bit_idx_q == 3'(DATA_BITS - 1)) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        state_d = STOP;
      end
      STOP: begin
        if (in == IDLE_LEVEL) begin
          if (par_err_q) par_err_inc = 1'b1;
          else           push        = 1'b1;
          state_d = IDLE;
        end else begin
          // Bad stop bit dominates; any parity result for this frame is dropped.
          frame_err_inc = 1'b1;
          state_d       = ERR;
        end
      end
      ERR: begin
        if (in == IDLE_LEVEL) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame datapath: config is captured at the start bit so mid-frame changes are ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_idx_q <= '0;
      shreg_q   <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en && (in != IDLE_LEVEL)) begin
            bit_idx_q <= '0;
            par_en_q  <= parity_en;
            par_odd_q <= parity_odd;
            par_err_q <= 1'b0;
          end
        end
        DATA: begin
          shreg_q   <= {in, shreg_q[7:1]};
          bit_idx_q <= bit_idx_q + 1'b1;
        end
        PARITY: begin
          par_err_q <= par_bad;
        end
        default: ;
      endcase
    end
  end

  // Saturating error counters; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!reset || clr_cnt) begin
      frame_err_cnt  <= '0;
      parity_err_cnt <= '0;
      overrun_cnt    <= '0;
    end else begin
      if (frame_err_inc) frame_err_cnt  <= CNT_W'(sat_inc(32'(frame_err_cnt),  32'(CNT_MAX)));
      if (par_err_inc)   parity_err_cnt <= CNT_W'(sat_inc(32'(parity_err_cnt), 32'(CNT_MAX)));
      if (overrun_inc)   overrun_cnt    <= CNT_W'(sat_inc(32'(overrun_cnt),    32'(CNT_MAX)));
    end
  end

  serial_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (shreg_q),
    .pop       (pop),
    .pop_data  (rd.rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (rd.fifo_count)
  );

endmodule

// File: tb/tb_serial_rx_ctrl.sv
// Directed bench for serial_rx_ctrl with a scoreboard on delivered bytes.
// Stimulus changes inputs 1 time unit after each rising edge.
// A monitor on the falling edge checks each accepted byte against the queue.
module tb_serial_rx_ctrl;
  import serial_rx_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic clk;
  logic reset;
  logic in;
  logic en;
  logic parity_en;
  logic parity_odd;
  logic clr_cnt;
  logic busy;
  logic [CNT_W-1:0] frame_err_cnt;
  logic [CNT_W-1:0] parity_err_cnt;
  logic [CNT_W-1:0] overrun_cnt;

  serial_rx_ctrl_if #(.DEPTH(DEPTH)) rd_if ();

  serial_rx_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .in             (in),
    .en             (en),
    .parity_en      (parity_en),
    .parity_odd     (parity_odd),
    .clr_cnt        (clr_cnt),
    .rd             (rd_if.master),
    .busy           (busy),
    .frame_err_cnt  (frame_err_cnt),
    .parity_err_cnt (parity_err_cnt),
    .overrun_cnt    (overrun_cnt)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame; leaves in at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input bit has_par, input logic par_bit,
                            input logic stop_bit, input bit rdy_at_stop, input bit clr_at_stop);
    in = 1'b0;
    tick();
    for (int i = 0; i < DATA_BITS; i++) begin
      in = d[i];
      tick();
    end
    if (has_par) begin
      in = par_bit;
      tick();
    end
    in = stop_bit;
    if (rdy_at_stop) rd_if.rd_ready = 1'b1;
    if (clr_at_stop) clr_cnt = 1'b1;
    tick();
    rd_if.rd_ready = 1'b0;
    clr_cnt = 1'b0;
  endtask

  task automatic drain();
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 20 && rd_if.fifo_count != 0; i++) tick();
    rd_if.rd_ready = 1'b0;
    check("drain_count", 32'(rd_if.fifo_count), 32'd0);
  endtask

  // Scoreboard monitor: every accepted byte must match the oldest expected one.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && rd_if.rd_valid && rd_if.rd_ready) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 32'(rd_if.rd_data), 32'hFFFF_FFFF);
        end else begin
          check("pop_data", 32'(rd_if.rd_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; in = 1'b1; en = 1'b1; parity_en = 1'b0; parity_odd = 1'b0;
    clr_cnt = 1'b0; rd_if.rd_ready = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(rd_if.rd_valid), 32'd0);
    check("rst_data",  32'(rd_if.rd_data), 32'd0);
    check("rst_count", 32'(rd_if.fifo_count), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_cnts",  32'({frame_err_cnt, parity_err_cnt, overrun_cnt}), 32'd0);
    reset = 1'b1;
    tick();

    // 1: basic byte A5, parity off
    send_frame(8'hA5, 0, 1'b0, 1'b1, 0, 0);
    exp_q.push_back(8'hA5);
    check("t1_valid", 32'(rd_if.rd_valid), 32'd1);
    check("t1_data",  32'(rd_if.rd_data), 32'hA5);
    check("t1_count", 32'(rd_if.fifo_count), 32'd1);
    check("t1_busy",  32'(busy), 32'd0);
    rd_if.rd_ready = 1'b1;
    tick();
    rd_if.rd_ready = 1'b0;
    check("t1_count_after", 32'(rd_if.fifo_count), 32'd0);
    check("t1_data_empty",  32'(rd_if.rd_data), 32'h00);

    // 2: even parity, good then bad parity bit
    parity_en = 1'b1; parity_odd = 1'b0;
    send_frame(8'h03, 1, 1'b0, 1'b1, 0, 0);
    exp_q.push_back(8'h03);
    check("t2_count_good", 32'(rd_if.fifo_count), 32'd1);
    send_frame(8'h03, 1, 1'b1, 1'b1, 0, 0);
    check("t2_par_err", 32'(parity_err_cnt), 32'd1);
    check("t2_count_bad", 32'(rd_if.fifo_count), 32'd1);
    drain();
    parity_en = 1'b0;

    // 3: bad stop bit, held low, then recovery
    send_frame(8'h3C, 0, 1'b0, 1'b0, 0, 0);
    check("t3_frame_err", 32'(frame_err_cnt), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    check("t3_busy_err", 32'(busy), 32'd1);
    check("t3_count", 32'(rd_if.fifo_count), 32'd0);
    in = 1'b1;
    tick();
    check("t3_busy_idle", 32'(busy), 32'd0);
    send_frame(8'h5A, 0, 1'b0, 1'b1, 0, 0);
    exp_q.push_back(8'h5A);
    check("t3_data", 32'(rd_if.rd_data), 32'h5A);
    drain();

    // 4: overflow with no consumer
    for (int b = 1; b <= 5; b++) begin
      send_frame(8'(b), 0, 1'b0, 1'b1, 0, 0);
      if (b <= 4) exp_q.push_back(8'(b));
      tick();
    end
    check("t4_count", 32'(rd_if.fifo_count), 32'd4);
    check("t4_overrun", 32'(overrun_cnt), 32'd1);
    drain();

    // 5: push into full FIFO with simultaneous pop
    for (int b = 8'h11; b <= 8'h14; b++) begin
      send_frame(8'(b), 0, 1'b0, 1'b1, 0, 0);
      exp_q.push_back(8'(b));
      tick();
    end
    check("t5_full", 32'(rd_if.fifo_count), 32'd4);
    send_frame(8'h15, 0, 1'b0, 1'b1, 1, 0);
    exp_q.push_back(8'h15);
    check("t5_count", 32'(rd_if.fifo_count), 32'd4);
    check("t5_overrun", 32'(overrun_cnt), 32'd1);
    drain();
    // back-to-back frames, no idle gap
    send_frame(8'h21, 0, 1'b0, 1'b1, 0, 0);
    exp_q.push_back(8'h21);
    send_frame(8'h22, 0, 1'b0, 1'b1, 0, 0);
    exp_q.push_back(8'h22);
    check("t5_b2b_count", 32'(rd_if.fifo_count), 32'd2);
    drain();

    // 6: reset mid-frame with bytes queued
    send_frame(8'h31, 0, 1'b0, 1'b1, 0, 0);
    send_frame(8'h32, 0, 1'b0, 1'b1, 0, 0);
    check("t6_count_pre", 32'(rd_if.fifo_count), 32'd2);
    in = 1'b0; tick();
    in = 1'b1; tick();
    in = 1'b0; tick();
    check("t6_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    tick();
    exp_q.delete();
    check("t6_count", 32'(rd_if.fifo_count), 32'd0);
    check("t6_valid", 32'(rd_if.rd_valid), 32'd0);
    check("t6_busy",  32'(busy), 32'd0);
    check("t6_cnts",  32'({frame_err_cnt, parity_err_cnt, overrun_cnt}), 32'd0);
    reset = 1'b1; in = 1'b1;
    tick();
    // clear coincident with a frame error
    send_frame(8'h77, 0, 1'b0, 1'b0, 0, 1);
    check("t6_clr_wins", 32'(frame_err_cnt), 32'd0);
    in = 1'b1; tick();
    send_frame(8'h77, 0, 1'b0, 1'b0, 0, 0);
    check("t6_frame_err", 32'(frame_err_cnt), 32'd1);
    in = 1'b1; tick();
    tick();

    check("scoreboard_left", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_rx_ctrl.md
Name: serial_rx_ctrl

Overview:
Receive-side controller for the one-bit-per-clock serial link.
- Sequences frame reception: start bit, 8 data bits LSB first, optional parity bit, stop bit.
- Applies the run-time configuration (enable, parity mode).
- Buffers good bytes in a small FIFO behind a valid/ready interface.
- Keeps saturating error counters for status readout.
- Sits between the serial pin and the byte consumer; replaces the bare done/out_byte pulse with flow-controlled delivery.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, 8, width of each error counter.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets).
- in  in  1  serial line; idle level 1.
- en  in  1  receive enable; gates detection of new start bits only.
- parity_en  in  1  1 = frame carries a parity bit after bit 7.
- parity_odd  in  1  1 = odd parity, 0 = even; ignored when parity_en=0.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  consumer accepts the head byte.
- rd_data  out  8  FIFO head byte; 8'h00 when empty.
- fifo_count  out  $clog2(DEPTH)+1  occupancy.
- busy  out  1  FSM not in IDLE.
- clr_cnt  in  1  synchronous clear of all error counters.
- frame_err_cnt  out  CNT_W  bad stop bits.
- parity_err_cnt  out  CNT_W  parity mismatches.
- overrun_cnt  out  CNT_W  good frames dropped because the FIFO was full.

Behaviour:
- Reset (reset==0 at a clock edge):
  - FSM goes to IDLE; FIFO pointers, fifo_count and all counters clear.
  - All outputs read 0.
  - Reset mid-frame discards the partial frame with no counter update.
- FSM states:
  - IDLE:
    - en=1 and in=0: go to DATA, bit index 0.
    - On the same cycle, latch parity_en and parity_odd. The frame uses the latched values, so config changes mid-frame have no effect.
  - DATA:
    - Shift in into the data register, LSB first.
    - After the 8th bit, go to PARITY if the latched parity_en=1, else go to STOP.
  - PARITY:
    - Sample in as the parity bit.
    - Error when (XOR of the 8 data bits XOR parity bit) != latched parity_odd.
    - Latch the error flag and go to STOP.
  - STOP:
    - in=1 with no parity error: push the byte into the FIFO, or count an overrun if the push is refused. Go to IDLE.
    - in=1 with a parity error: increment parity_err_cnt, push nothing, go to IDLE.
    - in=0: increment frame_err_cnt, push nothing, go to ERR. No parity count for that frame.
  - ERR: stay while in=0; go to IDLE when in=1.
- Back-to-back frames:
  - The cycle after STOP is IDLE and samples in.
  - A start bit there begins the next frame with no idle gap required.
- en deasserted mid-frame: the frame completes normally.
- Latency: the push is registered. rd_valid and rd_data are valid on the cycle after the clock edge that samples the stop bit.
- FIFO:
  - Pop when rd_valid && rd_ready.
  - Push and pop on the same cycle when full: the pop frees the slot, the push is accepted, count is unchanged, no overrun.
  - Push when full with no pop: byte dropped, overrun_cnt increments.
  - Pop when empty: ignored.
  - Pointers wrap modulo DEPTH.
- Counters:
  - Saturate at all-ones.
  - clr_cnt wins over a coincident increment; the counter reads 0 next cycle.
- busy=1 in DATA, PARITY, STOP and ERR.

Decomposition:
- Package serial_rx_pkg:
  - State enum: IDLE, DATA, PARITY, STOP, ERR.
  - Constants DATA_BITS=8, IDLE_LEVEL=1'b1.
  - Saturating-increment function.
- Sub-module serial_rx_fifo:
  - Synchronous FIFO parameterised by DEPTH and width.
  - Push/pop/full/empty/count interface.
  - Push-when-full-with-pop rule implemented inside.
- FSM, parity check and counters stay in serial_rx_ctrl.

Test Plan:
1. Parity off; after reset release send 0, bits 1,0,1,0,0,1,0,1, then 1 -> rd_valid=1 one cycle after the stop edge; rd_data=8'hA5; fifo_count=1; pulse rd_ready -> fifo_count=0, rd_data=8'h00.
2. parity_en=1, parity_odd=0; send 8'h03 with parity bit 0 then stop 1 -> byte accepted. Resend with parity bit 1 -> parity_err_cnt=1, fifo_count unchanged.
3. Parity off; send 8'h3C with stop bit 0, hold in=0 for 5 cycles -> frame_err_cnt=1, busy stays 1. Then in=1 -> IDLE; next frame 8'h5A is received correctly.
4. DEPTH=4, rd_ready=0; send 5 good frames 8'h01..8'h05 -> fifo_count=4, overrun_cnt=1. Drain -> reads 01,02,03,04 in order.
5. FIFO full; stop bit of a new frame sampled while rd_ready=1 -> count stays 4, overrun_cnt unchanged, new byte appears last. Also: two frames with the second start bit immediately after the first stop bit -> both bytes received.
6. reset=0 asserted mid-DATA with FIFO holding 2 bytes -> next cycle fifo_count=0, rd_valid=0, busy=0, counters 0. Also: clr_cnt on the cycle a frame error is counted -> frame_err_cnt=0.
